codec_reg_arbiter: RTL and testbench

- Shares the single WM8731 I2C register-write engine (24-bit frame: device address, then 16-bit register word) among NUM_REQ requesters.
- Typical requesters: power-up config sequencer, volume keys, mute, sample-rate select.
- Round-robin arbitration; owns the engine start/done handshake; retries on NACK or timeout; reports per-requester done or error.
- Runs on clk_50m. The engine's slow-domain status inputs are synchronised internally.

---
 rtl/codec_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/codec_reg_arbiter.sv | 168 ++++++++++++++++
 tb/tb_codec_reg_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/codec_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// codec_pkg: shared types and constants for the WM8731 register path
// Rev 1.0
// ----------------------------------------------------------------------
package codec_pkg;

  localparam int         FRAME_W         = 24;
  localparam logic [7:0] WM8731_DEV_ADDR = 8'h34;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_LOAD      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_WAIT_REL  = 3'd4,
    ST_RESP      = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// rr_arbiter: combinational rotate-priority pick, starting after ptr
// Rev 1.0
// ----------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [GW-1:0]      gnt,
  output logic               valid
);

  // Scan farthest offset first so the nearest set bit after ptr wins last.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % NUM_REQ]) begin
        gnt   = GW'((int'(ptr) + i) % NUM_REQ);
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ----------------------------------------------------------------------
// sync_2ff: two-flop synchroniser for slow or asynchronous level inputs
// Rev 1.0
// ----------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/codec_reg_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// codec_reg_arbiter: round-robin sharing of the WM8731 I2C write engine
// Rev 1.0
// ----------------------------------------------------------------------
module codec_reg_arbiter
  import codec_pkg::*;
#(
  parameter int         NUM_REQ     = 4,
  parameter logic [7:0] DEV_ADDR    = WM8731_DEV_ADDR,
  parameter int         MAX_RETRY   = 3,
  parameter int         TIMEOUT_CYC = 2500000
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic                 busy,
  output logic                 eng_start,
  output logic [FRAME_W-1:0]   eng_data,
  input  logic                 eng_done,
  input  logic                 eng_nack
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TIMER_SAT  = '1;
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  state_t               state_q, state_d;
  logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]        gnt_q, gnt_d;
  logic [RW-1:0]        retry_cnt_q, retry_cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 fail_q, fail_d;
  logic                 eng_start_q, eng_start_d;
  logic [FRAME_W-1:0]   eng_data_q, eng_data_d;

  logic [1:0]           status_s;
  logic                 done_s;
  logic                 nack_s;
  logic [GW-1:0]        arb_gnt;
  logic                 arb_valid;
  logic [15:0]          word [NUM_REQ];
  logic [NUM_REQ-1:0]   resp_vec;

  sync_2ff #(.WIDTH(2)) u_sync (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .d     ({eng_done, eng_nack}),
    .q     (status_s)
  );

  assign done_s = status_s[1];
  assign nack_s = status_s[0];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr (
    .req   (req),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
    assign word[gi] = req_data[16*gi +: 16];
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    retry_cnt_d = retry_cnt_q;
    timer_d     = timer_q;
    fail_d      = fail_q;
    eng_start_d = eng_start_q;
    eng_data_d  = eng_data_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) state_d = ST_ARB;
      end
      ST_ARB: begin
        // A request withdrawn before arbitration simply returns to idle.
        if (arb_valid) begin
          gnt_d       = arb_gnt;
          rr_ptr_d    = arb_gnt;
          retry_cnt_d = '0;
          state_d     = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (retry_cnt_q == '0) eng_data_d = {DEV_ADDR, word[gnt_q]};
        eng_start_d = 1'b1;
        timer_d     = '0;
        state_d     = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (timer_q != TIMER_SAT) timer_d = timer_q + TW'(1);
        if (done_s) begin
          eng_start_d = 1'b0;
          fail_d      = nack_s;
          state_d     = ST_WAIT_REL;
        end else if (timer_q == TIMER_LAST) begin
          eng_start_d = 1'b0;
          fail_d      = 1'b1;
          state_d     = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (!done_s) begin
          if (fail_q && (retry_cnt_q < RETRY_MAX)) begin
            retry_cnt_d = retry_cnt_q + RW'(1);
            state_d     = ST_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= GW'(NUM_REQ - 1);
      gnt_q       <= '0;
      retry_cnt_q <= '0;
      timer_q     <= '0;
      fail_q      <= 1'b0;
      eng_start_q <= 1'b0;
      eng_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      retry_cnt_q <= retry_cnt_d;
      timer_q     <= timer_d;
      fail_q      <= fail_d;
      eng_start_q <= eng_start_d;
      eng_data_q  <= eng_data_d;
    end
  end

  always_comb begin
    resp_vec         = '0;
    resp_vec[gnt_q]  = 1'b1;
  end

  assign done      = (state_q == ST_RESP && !fail_q) ? resp_vec : '0;
  assign err       = (state_q == ST_RESP &&  fail_q) ? resp_vec : '0;
  assign busy      = (state_q != ST_IDLE);
  assign eng_start = eng_start_q;
  assign eng_data  = eng_data_q;

endmodule
`default_nettype wire

// File: tb/tb_codec_reg_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_codec_reg_arbiter: directed vectors plus reset/fairness sequence
// Rev 1.0
// ----------------------------------------------------------------------
module tb_codec_reg_arbiter;

  localparam int N = 4;

  logic           clk_50m  = 1'b0;
  logic           rst_n    = 1'b1;
  logic [N-1:0]   req      = '0;
  logic [16*N-1:0] req_data = '0;
  logic [N-1:0]   done;
  logic [N-1:0]   err;
  logic           busy;
  logic           eng_start;
  logic [23:0]    eng_data;
  logic           eng_done = 1'b0;
  logic           eng_nack = 1'b0;

  int total = 0;
  int bad   = 0;

  always #10 clk_50m = ~clk_50m;

  codec_reg_arbiter #(
    .NUM_REQ     (N),
    .DEV_ADDR    (8'h34),
    .MAX_RETRY   (3),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .eng_start (eng_start),
    .eng_data  (eng_data),
    .eng_done  (eng_done),
    .eng_nack  (eng_nack)
  );

  // Engine model: answers a few cycles after start, NACKs the first
  // nack_plan attempts of a transaction, or never answers when hang is set.
  int nack_plan = 0;
  bit hang      = 1'b0;
  int attempt;
  int dly;

  always @(negedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      eng_done <= 1'b0;
      eng_nack <= 1'b0;
      attempt  <= 0;
      dly      <= 0;
    end else begin
      if (!busy) attempt <= 0;
      if (eng_done) begin
        if (!eng_start) begin
          eng_done <= 1'b0;
          eng_nack <= 1'b0;
        end
      end else if (eng_start && !hang) begin
        if (dly == 3) begin
          eng_done <= 1'b1;
          eng_nack <= (attempt < nack_plan);
          attempt  <= attempt + 1;
          dly      <= 0;
        end else begin
          dly <= dly + 1;
        end
      end else begin
        dly <= 0;
      end
    end
  end

  // Monitor: frames at each start rise, start-high lengths, pulse owners.
  logic [23:0] frames [$];
  int          lens   [$];
  int          pulses [$];
  int          mon_bad    = 0;
  bit          prev_start = 1'b0;
  int          cur_len    = 0;

  function automatic int pulse_code(input logic [N-1:0] d, input logic [N-1:0] e);
    for (int i = 0; i < N; i++) begin
      if (d[i]) return i;
      if (e[i]) return 100 + i;
    end
    return -1;
  endfunction

  always @(negedge clk_50m) begin
    if (!rst_n) begin
      prev_start <= 1'b0;
      cur_len    <= 0;
    end else begin
      if (eng_start && !prev_start) frames.push_back(eng_data);
      if (eng_start) cur_len <= prev_start ? cur_len + 1 : 1;
      if (!eng_start && prev_start) lens.push_back(cur_len);
      prev_start <= eng_start;
      if (!$onehot0(done | err)) mon_bad <= mon_bad + 1;
      if ((done | err) != '0) pulses.push_back(pulse_code(done, err));
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_pulses(input int target, input int limit, input string nm);
    int c;
    c = 0;
    while (pulses.size() < target && c < limit) begin
      @(negedge clk_50m); #1;
      c++;
    end
    chk(nm, int'(pulses.size() >= target), 1);
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (busy && c < 500) begin
      @(negedge clk_50m); #1;
      c++;
    end
    chk(nm, int'(busy), 0);
  endtask

  typedef struct {
    int          idx;
    logic [15:0] word;
    int          nacks;
    bit          hang;
    logic [23:0] exp_frame;
    int          exp_starts;
    int          exp_code;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] rm_words [4];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int fb;
    int lb;
    int pb;

    vecs[0] = '{idx:0, word:16'h047f, nacks:0,  hang:1'b0, exp_frame:24'h34047f, exp_starts:1, exp_code:0};
    vecs[1] = '{idx:2, word:16'h0c00, nacks:2,  hang:1'b0, exp_frame:24'h340c00, exp_starts:3, exp_code:2};
    vecs[2] = '{idx:3, word:16'h1201, nacks:99, hang:1'b0, exp_frame:24'h341201, exp_starts:4, exp_code:103};
    vecs[3] = '{idx:1, word:16'h0a05, nacks:0,  hang:1'b1, exp_frame:24'h340a05, exp_starts:4, exp_code:101};
    vecs[4] = '{idx:0, word:16'h0001, nacks:3,  hang:1'b0, exp_frame:24'h340001, exp_starts:4, exp_code:0};
    vecs[5] = '{idx:2, word:16'h0e4c, nacks:1,  hang:1'b0, exp_frame:24'h340e4c, exp_starts:2, exp_code:2};
    rm_words = '{16'h1e01, 16'h0c12, 16'h0a23, 16'h0834};

    // Reset state, both during and just after reset.
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_50m);
    #1;
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_start", int'(eng_start), 0);
    chk("rst_data", int'(eng_data), 0);
    @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_50m);
    #1;
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_start", int'(eng_start), 0);

    // Single-requester vectors: ack, NACK retry, exhaustion, timeout.
    for (int v = 0; v < 6; v++) begin
      fb = frames.size();
      lb = lens.size();
      pb = pulses.size();
      nack_plan = vecs[v].nacks;
      hang      = vecs[v].hang;
      req_data[16*vecs[v].idx +: 16] = vecs[v].word;
      req = '0;
      req[vecs[v].idx] = 1'b1;
      wait_pulses(pb + 1, 3000, "v_pulse_seen");
      req  = '0;
      hang = 1'b0;
      wait_idle("v_idle");
      repeat (5) @(negedge clk_50m);
      #1;
      chk("v_starts", frames.size() - fb, vecs[v].exp_starts);
      for (int k = fb; k < frames.size(); k++)
        chk("v_frame", int'(frames[k]), int'(vecs[v].exp_frame));
      chk("v_pulse_cnt", pulses.size() - pb, 1);
      if (pulses.size() > pb) chk("v_pulse_who", pulses[pb], vecs[v].exp_code);
      if (vecs[v].hang && lens.size() > lb) chk("v_timeout_len", lens[lb], 100);
    end

    // Reset mid-transfer, then fairness with all four held.
    nack_plan = 0;
    hang      = 1'b1;
    for (int i = 0; i < N; i++) req_data[16*i +: 16] = rm_words[i];
    req = '1;
    fb = 0;
    while (!eng_start && fb < 50) begin
      @(negedge clk_50m); #1;
      fb++;
    end
    chk("rm_start_seen", int'(eng_start), 1);
    repeat (10) @(negedge clk_50m);
    #3 rst_n = 1'b0;
    #1;
    chk("rm_start_low", int'(eng_start), 0);
    chk("rm_busy_low", int'(busy), 0);
    chk("rm_data_zero", int'(eng_data), 0);
    chk("rm_pulses_zero", int'(done | err), 0);
    hang = 1'b0;
    @(negedge clk_50m);
    fb = frames.size();
    pb = pulses.size();
    rst_n = 1'b1;
    wait_pulses(pb + 5, 1000, "fair_pulses_seen");
    req = '0;
    wait_idle("fair_idle");
    repeat (5) @(negedge clk_50m);
    #1;
    for (int k = 0; k < 5; k++) begin
      if (fb + k < frames.size())
        chk("fair_frame", int'(frames[fb+k]), int'({8'h34, rm_words[k % 4]}));
      if (pb + k < pulses.size())
        chk("fair_pulse", pulses[pb+k], k % 4);
    end

    chk("pulse_onehot", mon_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
